// File: rtl/pdm_demod_pkg.sv
// rtl/pdm_demod_pkg.sv - shared constants, state encoding and log2 helper for the PDM receiver
package pdm_demod_pkg;

    localparam int CIC_ORDER = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } pdm_demod_state_t;

    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pdm_cic_decim.sv
// rtl/pdm_cic_decim.sv - 3-stage CIC decimator: integrators, decimation counter, combs, scale and clamp
module pdm_cic_decim
    import pdm_demod_pkg::*;
#(
    parameter int NBITS = 10,
    parameter int DECIM = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic             i_bit,
    output logic [NBITS-1:0] o_result,
    output logic             o_result_valid
);

    localparam int LOG2D = log2_ceil(DECIM);
    localparam int W     = CIC_ORDER * LOG2D + 1;
    localparam int SHIFT = W - 1 - NBITS;
    localparam int SHR   = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHL   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int WW    = W + NBITS;
    localparam logic [WW-1:0] MAXV = WW'((1 << NBITS) - 1);

    logic [W-1:0]     r_integ    [CIC_ORDER];
    logic [W-1:0]     r_comb_dly [CIC_ORDER];
    logic [LOG2D-1:0] r_dec;
    logic [NBITS-1:0] r_result;
    logic             r_result_valid;

    logic [W-1:0]     w_integ_next [CIC_ORDER];
    logic [W-1:0]     w_comb       [CIC_ORDER];
    logic [WW-1:0]    w_wide;
    logic [NBITS-1:0] w_scaled;

    // Integrators chain without pipeline delay so each tick is a textbook cascade update.
    always_comb begin
        w_integ_next[0] = r_integ[0] + W'(i_bit);
        for (int k = 1; k < CIC_ORDER; k++) begin
            w_integ_next[k] = r_integ[k] + w_integ_next[k-1];
        end
        w_comb[0] = w_integ_next[CIC_ORDER-1] - r_comb_dly[0];
        for (int k = 1; k < CIC_ORDER; k++) begin
            w_comb[k] = w_comb[k-1] - r_comb_dly[k];
        end
        w_wide   = (WW'(w_comb[CIC_ORDER-1]) << SHL) >> SHR;
        w_scaled = (w_wide > MAXV) ? '1 : w_wide[NBITS-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                r_integ[k]    <= '0;
                r_comb_dly[k] <= '0;
            end
            r_dec          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else if (i_clr) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                r_integ[k]    <= '0;
                r_comb_dly[k] <= '0;
            end
            r_dec          <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (i_tick) begin
                for (int k = 0; k < CIC_ORDER; k++) begin
                    r_integ[k] <= w_integ_next[k];
                end
                if (r_dec == LOG2D'(DECIM - 1)) begin
                    r_dec         <= '0;
                    r_comb_dly[0] <= w_integ_next[CIC_ORDER-1];
                    for (int k = 1; k < CIC_ORDER; k++) begin
                        r_comb_dly[k] <= w_comb[k-1];
                    end
                    r_result       <= w_scaled;
                    r_result_valid <= 1'b1;
                end else begin
                    r_dec <= r_dec + 1'b1;
                end
            end
        end
    end

    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;

endmodule

// File: rtl/pdm_demod.sv
// rtl/pdm_demod.sv - PDM mic receiver: m_clk divider, input sync, warmup FSM, CIC decimation to PCM
// Optional peak tracker enabled by defining PDM_DEMOD_PEAK_EN.
module pdm_demod
    import pdm_demod_pkg::*;
#(
    parameter int NBITS   = 10,
    parameter int CLK_DIV = 40,
    parameter int DECIM   = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_m_data,
`ifdef PDM_DEMOD_PEAK_EN
    input  logic             i_peak_clr,
    output logic [NBITS-1:0] o_peak,
`endif
    output logic             o_m_clk,
    output logic             o_m_lrsel,
    output logic [NBITS-1:0] o_out,
    output logic             o_out_valid
);

    localparam int DIV_W = log2_ceil(CLK_DIV);
    localparam int HALF  = CLK_DIV / 2;

    pdm_demod_state_t r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_m_clk;
    logic [1:0]       r_sync;
    logic [1:0]       r_discard;
    logic [NBITS-1:0] r_out;
    logic             r_out_valid;

    logic [DIV_W-1:0] w_div_next;
    logic             w_tick;
    logic             w_clr;
    logic [NBITS-1:0] w_result;
    logic             w_result_valid;

    assign w_div_next = (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
    // Last high cycle of m_clk: data has been stable for half a period when it is captured.
    assign w_tick     = (r_state != ST_IDLE) && (r_div == DIV_W'(HALF - 1));
    assign w_clr      = (r_state == ST_IDLE) || !i_en;

    pdm_cic_decim #(
        .NBITS (NBITS),
        .DECIM (DECIM)
    ) u_cic (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_clr          (w_clr),
        .i_tick         (w_tick),
        .i_bit          (r_sync[1]),
        .o_result       (w_result),
        .o_result_valid (w_result_valid)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_WARMUP;
            r_div       <= '0;
            r_m_clk     <= 1'b0;
            r_sync      <= '0;
            r_discard   <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], i_m_data};
            r_out_valid <= 1'b0;
            if (!i_en) begin
                r_state   <= ST_IDLE;
                r_div     <= '0;
                r_m_clk   <= 1'b0;
                r_discard <= '0;
            end else begin
                if (r_state != ST_IDLE) begin
                    r_div   <= w_div_next;
                    r_m_clk <= (w_div_next < DIV_W'(HALF));
                end
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_WARMUP;
                        r_div   <= '0;
                        r_m_clk <= 1'b1;
                    end
                    ST_WARMUP: begin
                        if (w_result_valid) begin
                            if (r_discard == 2'd2) r_state <= ST_RUN;
                            else                   r_discard <= r_discard + 2'd1;
                        end
                    end
                    ST_RUN: begin
                        if (w_result_valid) begin
                            r_out       <= w_result;
                            r_out_valid <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef PDM_DEMOD_PEAK_EN
    logic [NBITS-1:0] r_peak;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_peak <= '0;
        end else if (i_peak_clr) begin
            r_peak <= r_out_valid ? r_out : '0;
        end else if (r_out_valid && (r_out > r_peak)) begin
            r_peak <= r_out;
        end
    end

    assign o_peak = r_peak;
`endif

    assign o_m_clk     = r_m_clk;
    assign o_m_lrsel   = 1'b0;
    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_pdm_demod.sv
// tb/tb_pdm_demod.sv - self-checking bench for pdm_demod against a convolution reference model
module tb_pdm_demod;

    localparam int NBITS   = 10;
    localparam int CLK_DIV = 40;
    localparam int DECIM   = 64;
    localparam int WIN     = CLK_DIV * DECIM;
    localparam int HLEN    = 3 * (DECIM - 1) + 1;
    localparam int SHIFT   = 3 * $clog2(DECIM) - NBITS;
    localparam int MAXV    = (1 << NBITS) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic m_data = 1'b0;
    wire  m_clk;
    wire  m_lrsel;
    wire  pcm_valid;
    wire  [NBITS-1:0] pcm;
`ifdef PDM_DEMOD_PEAK_EN
    logic peak_clr = 1'b0;
    wire  [NBITS-1:0] peak;
    int   exp_peak = 0;
`endif

    always #5 clk = ~clk;

    pdm_demod #(
        .NBITS   (NBITS),
        .CLK_DIV (CLK_DIV),
        .DECIM   (DECIM)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_m_data    (m_data),
`ifdef PDM_DEMOD_PEAK_EN
        .i_peak_clr  (peak_clr),
        .o_peak      (peak),
`endif
        .o_m_clk     (m_clk),
        .o_m_lrsel   (m_lrsel),
        .o_out       (pcm),
        .o_out_valid (pcm_valid)
    );

    int vectors = 0;
    int errors = 0;
    int h1[DECIM];
    int h2[2*DECIM-1];
    int h[HLEN];
    bit bits[$];
    int mode = 1;
    int din = 0;
    int sd_acc = 0;
    int strobes = 0;
    int cyc = 0;
    int last_strobe_cyc = 0;
    int exp_last = 0;
    int rise_cnt = 0;
    int last_rise = 0;
    int high_cnt = 0;
    bit prev_mclk = 1'b0;
    int held;
    int s0;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Mic-side bit source: constant, alternating, random or first-order sigma-delta of din.
    function automatic bit next_bit();
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return bit'(bits.size() % 2);
            3: return bit'($urandom_range(0, 1));
            default: begin
                sd_acc += din;
                if (sd_acc >= (1 << NBITS)) begin
                    sd_acc -= (1 << NBITS);
                    return 1'b1;
                end
                return 1'b0;
            end
        endcase
    endfunction

    // Expected PCM for decimation window k: bitstream convolved with boxcar^3, scaled and clamped.
    function automatic int model(input int k);
        int n;
        int y;
        int s;
        n = DECIM * (k + 1) - 1;
        y = 0;
        for (int j = 0; j < HLEN; j++) begin
            if (n - j >= 0 && n - j < bits.size()) y += h[j] * int'(bits[n-j]);
        end
        s = y >> SHIFT;
        if (s > MAXV) s = MAXV;
        return s;
    endfunction

    task automatic start();
        bits.delete();
        strobes = 0;
        cyc = 0;
        rise_cnt = 0;
        prev_mclk = 1'b0;
        high_cnt = 0;
    endtask

    task automatic step();
        int e;
        bit pchk;
        pchk = 1'b0;
`ifdef PDM_DEMOD_PEAK_EN
        if (peak_clr || pcm_valid) begin
            if (peak_clr)               exp_peak = pcm_valid ? exp_last : 0;
            else if (exp_last > exp_peak) exp_peak = exp_last;
            pchk = 1'b1;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
`ifdef PDM_DEMOD_PEAK_EN
        if (pchk) chk("peak", int'(peak), exp_peak);
`endif
        if (m_clk && !prev_mclk) begin
            if (rise_cnt >= 2 && rise_cnt < 6) begin
                chk("mclk_period", cyc - last_rise, CLK_DIV);
                chk("mclk_high", high_cnt, CLK_DIV / 2);
            end
            rise_cnt++;
            last_rise = cyc;
            high_cnt = 0;
            m_data = next_bit();
            bits.push_back(m_data);
        end
        if (m_clk) high_cnt++;
        prev_mclk = m_clk;
        if (pcm_valid) begin
            e = model(strobes + 3);
            chk("pcm", int'(pcm), e);
            if (strobes == 0) chk_range("first_latency", cyc, 4 * WIN - 40, 4 * WIN + 80);
            else              chk("strobe_spacing", cyc - last_strobe_cyc, WIN);
            last_strobe_cyc = cyc;
            strobes++;
            exp_last = e;
        end
    endtask

    task automatic run_strobes(input int n);
        int target;
        int budget;
        target = strobes + n;
        budget = n * WIN + ((strobes == 0) ? 4 * WIN : 0) + 100;
        for (int t = 0; t < budget && strobes < target; t++) step();
        chk("strobe_count", strobes, target);
    endtask

`ifdef PDM_DEMOD_PEAK_EN
    task automatic pulse_clr();
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < DECIM; i++) h1[i] = 1;
        for (int i = 0; i < 2 * DECIM - 1; i++) h2[i] = 0;
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        for (int i = 0; i < DECIM; i++)
            for (int j = 0; j < DECIM; j++) h2[i+j] += h1[i] * h1[j];
        for (int i = 0; i < 2 * DECIM - 1; i++)
            for (int j = 0; j < DECIM; j++) h[i+j] += h2[i] * h1[j];

        en = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mclk", int'(m_clk), 0);
        chk("rst_pcm", int'(pcm), 0);
        chk("rst_valid", int'(pcm_valid), 0);
        chk("lrsel", int'(m_lrsel), 0);
`ifdef PDM_DEMOD_PEAK_EN
        chk("rst_peak", int'(peak), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        start();

        mode = 1; run_strobes(3); chk("const1", int'(pcm), MAXV);
        mode = 0; run_strobes(3); chk("const0", int'(pcm), 0);
        mode = 2; run_strobes(3); chk("alternating", int'(pcm), 1 << (NBITS - 1));
        mode = 3; run_strobes(1);
        mode = 4; din = 300;  sd_acc = 0; run_strobes(3); chk_range("din300", int'(pcm), 298, 302);
        din = 0;               sd_acc = 0; run_strobes(3); chk_range("din0", int'(pcm), 0, 2);
        din = MAXV;            sd_acc = 0; run_strobes(3); chk_range("din1023", int'(pcm), MAXV - 2, MAXV);
`ifdef PDM_DEMOD_PEAK_EN
        din = 700; sd_acc = 0; run_strobes(3);
        pulse_clr();
        run_strobes(1);
        chk_range("peak700", int'(peak), 698, 702);
        din = 200; sd_acc = 0; run_strobes(2);
        chk_range("peak_hold700", int'(peak), 698, 702);
        pulse_clr();
        chk("peak_cleared", int'(peak), 0);
        run_strobes(1);
        chk_range("peak200", int'(peak), 198, 202);
`endif

        repeat (500) step();
        en = 1'b0;
        step();
        chk("en_low_mclk", int'(m_clk), 0);
        s0 = strobes;
        held = exp_last;
        repeat (2000) step();
        chk("idle_no_strobe", strobes, s0);
        chk("idle_hold", int'(pcm), held);
        en = 1'b1;
        start();
        mode = 3;
        repeat (9000) step();
        chk("warmup_no_strobe", strobes, 0);
        chk("warmup_hold", int'(pcm), held);
        run_strobes(1);

        repeat (500) step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mclk", int'(m_clk), 0);
        chk("async_rst_pcm", int'(pcm), 0);
        chk("async_rst_valid", int'(pcm_valid), 0);
        exp_last = 0;
`ifdef PDM_DEMOD_PEAK_EN
        chk("async_rst_peak", int'(peak), 0);
        exp_peak = 0;
`endif
        s0 = strobes;
        repeat (500) step();
        chk("rst_no_strobe", strobes, s0);
        chk("rst_hold_pcm", int'(pcm), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
